// File: rtl/pbit_seq_pkg.sv
// pbit_seq_pkg: sequencer state type and the reset-time default mask pattern.
package pbit_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} seq_state_t;

    function automatic logic default_mask_bit(input int pbit, input int group, input int n_groups);
        return (pbit % n_groups) == group;
    endfunction

endpackage

// File: rtl/pbit_group_mask_table.sv
// pbit_group_mask_table: per-group p-bit enable masks with a range-checked write port.
// SKIP_EMPTY_GROUPS_EN adds a per-group non-empty flag vector.
module pbit_group_mask_table
    import pbit_seq_pkg::*;
#(
    parameter int N_PBITS = 7,
    parameter int N_GROUPS = 3,
    localparam int GW = $clog2(N_GROUPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic               wr_ok,
    input  logic [GW-1:0]      addr,
    input  logic [N_PBITS-1:0] wdata,
    input  logic [GW-1:0]      rd_addr,
    output logic [N_PBITS-1:0] rd_mask,
`ifdef SKIP_EMPTY_GROUPS_EN
    output logic [N_GROUPS-1:0] nonempty,
`endif
    output logic               err
);

    logic [N_PBITS-1:0] mask [N_GROUPS];
    logic in_range;

    assign in_range = int'(addr) < N_GROUPS;
    assign rd_mask = mask[rd_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < N_GROUPS; g++)
                for (int i = 0; i < N_PBITS; i++)
                    mask[g][i] <= default_mask_bit(i, g, N_GROUPS);
            err <= 1'b0;
        end else begin
            err <= we && !(wr_ok && in_range);
            if (we && wr_ok && in_range)
                mask[addr] <= wdata;
        end
    end

`ifdef SKIP_EMPTY_GROUPS_EN
    always_comb begin
        nonempty = '0;
        for (int g = 0; g < N_GROUPS; g++)
            nonempty[g] = |mask[g];
    end
`endif

endmodule

// File: rtl/pbit_group_sequencer.sv
// pbit_group_sequencer: steps p-bit enable masks group by group for a programmed dwell and sweep count.
// SKIP_EMPTY_GROUPS_EN skips all-zero groups without spending dwell on them.
module pbit_group_sequencer
    import pbit_seq_pkg::*;
#(
    parameter int N_PBITS = 7,
    parameter int N_GROUPS = 3,
    parameter int DWELL_W = 8,
    parameter int SWEEP_W = 16,
    localparam int GW = $clog2(N_GROUPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [SWEEP_W-1:0] num_sweeps,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               cfg_we,
    input  logic [GW-1:0]      cfg_addr,
    input  logic [N_PBITS-1:0] cfg_mask,
    output logic [N_PBITS-1:0] pbit_en,
    output logic [GW-1:0]      group_idx,
    output logic               busy,
    output logic [SWEEP_W-1:0] sweep_count,
    output logic               done,
    output logic               cfg_err
);

    seq_state_t state, state_n;
    logic [GW-1:0] group_n, first_g, adv_g;
    logic adv_wrap, any_ne;
    logic [DWELL_W-1:0] dwell_lat, dwell_n, cnt, cnt_n;
    logic [SWEEP_W-1:0] target, target_n, sweep_n;
    logic [N_PBITS-1:0] rd_mask;

`ifdef SKIP_EMPTY_GROUPS_EN
    logic [N_GROUPS-1:0] nonempty;
`endif

    pbit_group_mask_table #(
        .N_PBITS (N_PBITS),
        .N_GROUPS(N_GROUPS)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .we      (cfg_we),
        .wr_ok   (state == IDLE),
        .addr    (cfg_addr),
        .wdata   (cfg_mask),
        .rd_addr (group_n),
        .rd_mask (rd_mask),
`ifdef SKIP_EMPTY_GROUPS_EN
        .nonempty(nonempty),
`endif
        .err     (cfg_err)
    );

`ifdef SKIP_EMPTY_GROUPS_EN
    // Scan downwards so the nearest non-empty group wins; k=N_GROUPS revisits the current group.
    always_comb begin
        logic [GW-1:0] c;
        first_g = '0;
        adv_g = '0;
        adv_wrap = 1'b0;
        c = '0;
        for (int k = N_GROUPS - 1; k >= 0; k--)
            if (nonempty[GW'(k)]) first_g = GW'(k);
        for (int k = N_GROUPS; k >= 1; k--) begin
            c = GW'((int'(group_idx) + k) % N_GROUPS);
            if (nonempty[c]) begin
                adv_g = c;
                adv_wrap = int'(group_idx) + k >= N_GROUPS;
            end
        end
    end
    assign any_ne = |nonempty;
`else
    assign first_g = '0;
    assign any_ne = 1'b1;
    assign adv_wrap = group_idx == GW'(N_GROUPS - 1);
    assign adv_g = adv_wrap ? '0 : group_idx + GW'(1);
`endif

    always_comb begin
        state_n = state;
        group_n = group_idx;
        cnt_n = cnt;
        dwell_n = dwell_lat;
        target_n = target;
        sweep_n = sweep_count;
        case (state)
            IDLE: if (start && !stop) begin
                dwell_n = (dwell == '0) ? DWELL_W'(1) : dwell;
                target_n = num_sweeps;
                cnt_n = dwell_n - DWELL_W'(1);
                sweep_n = '0;
                group_n = first_g;
                state_n = any_ne ? RUN : FINISH;
            end
            RUN: if (stop) begin
                state_n = IDLE;
                group_n = '0;
            end else if (cnt != '0) begin
                cnt_n = cnt - DWELL_W'(1);
            end else begin
                cnt_n = dwell_lat - DWELL_W'(1);
                group_n = adv_g;
                if (adv_wrap)
                    sweep_n = sweep_count + SWEEP_W'(1);
                if (adv_wrap && target != '0 && sweep_n == target) begin
                    state_n = FINISH;
                    group_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            group_idx <= '0;
            cnt <= '0;
            dwell_lat <= '0;
            target <= '0;
            sweep_count <= '0;
            pbit_en <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            group_idx <= group_n;
            cnt <= cnt_n;
            dwell_lat <= dwell_n;
            target <= target_n;
            sweep_count <= sweep_n;
            pbit_en <= (state_n == RUN) ? rd_mask : '0;
            busy <= state_n == RUN;
            done <= state_n == FINISH;
        end
    end

endmodule

// File: tb/tb_pbit_group_sequencer.sv
// tb_pbit_group_sequencer: directed and randomized runs checked against a sweep-level arithmetic model.
module tb_pbit_group_sequencer;

    localparam int NP = 7, NG = 3, DW = 8, SW = 16;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, cfg_we = 1'b0;
    logic [SW-1:0] num_sweeps = '0;
    logic [DW-1:0] dwell = '0;
    logic [1:0] cfg_addr = '0;
    logic [NP-1:0] cfg_mask = '0;
    logic [NP-1:0] pbit_en;
    logic [1:0] group_idx;
    logic busy, done, cfg_err;
    logic [SW-1:0] sweep_count;

    logic [NP-1:0] mm [NG];
    int n_cmp = 0, n_bad = 0;

    pbit_group_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .num_sweeps (num_sweeps),
        .dwell      (dwell),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_mask   (cfg_mask),
        .pbit_en    (pbit_en),
        .group_idx  (group_idx),
        .busy       (busy),
        .sweep_count(sweep_count),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        for (int g = 0; g < NG; g++)
            for (int i = 0; i < NP; i++)
                mm[g][i] = (i % NG) == g;
    endtask

    task automatic check_idle(input int sweeps);
        check("idle_pbit", pbit_en, 0);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_group", group_idx, 0);
        check("idle_sweeps", sweep_count, sweeps);
    endtask

    task automatic cfg_write(input int a, input logic [NP-1:0] m);
        cfg_we = 1'b1;
        cfg_addr = 2'(a);
        cfg_mask = m;
        tick();
        cfg_we = 1'b0;
        check("cfg_err_idle", cfg_err, a >= NG);
        if (a < NG) mm[a] = m;
        tick();
        check("cfg_err_clear", cfg_err, 0);
    endtask

    // Expected enables come from the cycle offset alone: group = (c / dwell) mod NG, sweep = c / (dwell*NG).
    task automatic do_run(input int ns, input int dw, input int stop_at, input bit poke);
        int dl, per, total, g;
        logic err_next;
        dl = (dw == 0) ? 1 : dw;
        per = dl * NG;
        total = (ns == 0) ? (1 << 30) : ns * per;
        err_next = 1'b0;
        num_sweeps = SW'(ns);
        dwell = DW'(dw);
        start = 1'b1;
        tick();
        start = 1'b0;
        num_sweeps = SW'($urandom);
        dwell = DW'($urandom);
        for (int c = 0; c < 5000; c++) begin
            if (c == total) begin
                check("fin_done", done, 1);
                check("fin_busy", busy, 0);
                check("fin_pbit", pbit_en, 0);
                check("fin_sweeps", sweep_count, ns);
                check("fin_err", cfg_err, err_next);
                err_next = poke;
                cfg_we = poke;
                cfg_addr = 2'($urandom);
                cfg_mask = NP'($urandom);
                tick();
                cfg_we = 1'b0;
                check("post_done", done, 0);
                check("post_busy", busy, 0);
                check("post_pbit", pbit_en, 0);
                check("post_sweeps", sweep_count, ns);
                check("post_err", cfg_err, err_next);
                return;
            end
            g = (c / dl) % NG;
            check("run_pbit", pbit_en, mm[g]);
            check("run_group", group_idx, g);
            check("run_busy", busy, 1);
            check("run_done", done, 0);
            check("run_sweeps", sweep_count, (c / per) % 65536);
            check("run_err", cfg_err, err_next);
            err_next = 1'b0;
            if (poke && c == 1) begin
                cfg_we = 1'b1;
                cfg_addr = 2'($urandom);
                cfg_mask = NP'($urandom);
                start = 1'b1;
                err_next = 1'b1;
            end
            if (c == stop_at) begin
                stop = 1'b1;
                tick();
                stop = 1'b0;
                cfg_we = 1'b0;
                start = 1'b0;
                check_idle(c / per);
                check("stop_err", cfg_err, err_next);
                return;
            end
            tick();
            cfg_we = 1'b0;
            start = 1'b0;
        end
        check("run_timeout", 0, 1);
    endtask

    initial begin
        int ns, dw, dl, sa;
        reset_model();
        repeat (3) tick();
        check("rst_pbit", pbit_en, 0);
        check("rst_busy", busy, 0);
        check("rst_err", cfg_err, 0);
        rst = 1'b0;
        tick();
        check_idle(0);

        cfg_write(0, 7'b1010000);
        cfg_write(1, 7'b0101000);
        cfg_write(2, 7'b0000111);
        do_run(2, 2, -1, 1'b0);
        do_run(1, 0, -1, 1'b0);
        do_run(0, 1, 9, 1'b0);
        do_run(1, 1, -1, 1'b1);
        do_run(1, 1, -1, 1'b0);
        cfg_write(3, 7'b1111111);

        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        check("both_busy", busy, 0);
        check("both_pbit", pbit_en, 0);

        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 1) == 1) cfg_write(int'($urandom_range(0, 3)), NP'($urandom));
            ns = int'($urandom_range(0, 3));
            dw = int'($urandom_range(0, 3));
            dl = (dw == 0) ? 1 : dw;
            if (ns == 0) sa = int'($urandom_range(0, 25));
            else if ($urandom_range(0, 1) == 1) sa = -1;
            else sa = int'($urandom_range(0, ns * dl * NG - 1));
            do_run(ns, dw, sa, 1'($urandom_range(0, 1)));
            tick();
        end

        num_sweeps = '0;
        dwell = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        check("pre_rst_busy", busy, 1);
        check("pre_rst_sweeps", sweep_count, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_pbit", pbit_en, 0);
        check("arst_busy", busy, 0);
        check("arst_group", group_idx, 0);
        check("arst_sweeps", sweep_count, 0);
        check("arst_done", done, 0);
        check("arst_err", cfg_err, 0);
        tick();
        rst = 1'b0;
        reset_model();
        do_run(1, 1, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
